bitwise_pipe: RTL

// - Pipelined, parametrised successor to the combinational bitwise ALU slice: AND/OR/XOR/NOT,

---
 rtl/bitwise_pipe.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bitwise_pipe.sv
// bitwise_pipe: pipelined bitwise / rotate / shift / bit-reverse unit with
// valid/ready handshakes on both sides and STAGES register stages.
// Optional feature macro: BITWISE_COUNT_EN adds POPCNT (op 10) and CLZ (op 11).
module bitwise_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [1:0]      in_size,
    input  logic            in_use_c,
    input  logic            in_carry,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_carry,
    output logic            out_illegal
);
    // Shift work vector: room for a doubled (n+1)-bit value.
    localparam int unsigned DW = 2 * XLEN + 2;
    localparam int unsigned IW = $clog2(DW);
    localparam int unsigned AW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_ROR  = 4'd4;
    localparam logic [3:0] OP_ROL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SAR  = 4'd8;
    localparam logic [3:0] OP_FLIP = 4'd9;
`ifdef BITWISE_COUNT_EN
    localparam logic [3:0] OP_POPCNT = 4'd10;
    localparam logic [3:0] OP_CLZ    = 4'd11;
`endif

    // Every op is reduced to "right-shift src by sh, then extract".
    // lo_mode: result = u[n-1:0], carry = u[n]; else result = u[n:1], carry = u[0].
    typedef struct packed {
        logic [DW-1:0] src;
        logic [6:0]    sh;
        logic [6:0]    n;
        logic          lo_mode;
        logic          carry_en;
        logic          fill_en;
        logic          fill;
        logic          illegal;
    } dec_t;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            carry;
        logic            illegal;
    } res_t;

    function automatic logic [XLEN-1:0] f_mask(input logic [6:0] n);
        return XLEN'(~({DW{1'b1}} << n));
    endfunction

    // Decode, size-mask and build the shift source for one request.
    function automatic dec_t f_dec(input logic [3:0] op, input logic [1:0] size,
                                   input logic use_c, input logic cin,
                                   input logic [XLEN-1:0] a_in, input logic [XLEN-1:0] b_in);
        dec_t            d;
        logic [6:0]      n, k, kc, m, r, r_n, r_n1;
        logic [XLEN-1:0] mask, a, b, rev;
        logic [DW-1:0]   x;
        logic            cin_e, sign;
`ifdef BITWISE_COUNT_EN
        logic [6:0]      cnt;
`endif
        k = b_in[6:0];
        case (size)
            2'd0:    begin n = 7'd8;  r_n = k & 7'd7;  r_n1 = k % 7'd9;  end
            2'd1:    begin n = 7'd16; r_n = k & 7'd15; r_n1 = k % 7'd17; end
            2'd2:    begin n = 7'd32; r_n = k & 7'd31; r_n1 = k % 7'd33; end
            default: begin n = 7'd64; r_n = k & 7'd63; r_n1 = k % 7'd65; end
        endcase
        mask  = f_mask(n);
        a     = a_in & mask;
        b     = b_in & mask;
        cin_e = use_c & cin;
        sign  = a[AW'(n - 7'd1)];
        kc    = (k > n) ? n + 7'd1 : k;
        m     = use_c ? n + 7'd1 : n;
        r     = use_c ? r_n1 : r_n;
        x     = DW'(a) | (DW'(cin_e) << n);
        for (int i = 0; i < XLEN; i++) rev[i] = a[XLEN-1-i];

        d          = '0;
        d.n        = n;
        d.lo_mode  = 1'b1;
        d.carry_en = use_c;
        d.illegal  = (32'(n) > XLEN);
        case (op)
            OP_AND:  begin d.src = DW'(a & b);  d.carry_en = 1'b0; end
            OP_OR:   begin d.src = DW'(a | b);  d.carry_en = 1'b0; end
            OP_XOR:  begin d.src = DW'(a ^ b);  d.carry_en = 1'b0; end
            OP_NOT:  begin d.src = DW'(~a);     d.carry_en = 1'b0; end
            OP_ROR, OP_ROL: begin
                // Two copies of the m-bit value back to back make the rotate a plain shift.
                d.src = x | (x << m);
                d.sh  = (op == OP_ROR) ? r : m - r;
            end
            OP_SHL: begin
                // Left shift of {cin,a} by kc expressed as a right shift from the top.
                d.src = x << (n + 7'd1);
                d.sh  = n + 7'd1 - kc;
            end
            OP_SHR, OP_SAR: begin
                // {a,cin}: carry falls out at bit 0, sign fills above bit n for SAR.
                d.src = (DW'(a) << 1) | DW'(cin_e);
                if (op == OP_SAR && sign) d.src = d.src | ({DW{1'b1}} << (n + 7'd1));
                d.sh      = kc;
                d.lo_mode = 1'b0;
                d.fill_en = (op == OP_SHR) && use_c && (k != 7'd0);
                d.fill    = cin;
            end
            OP_FLIP: begin
                d.src      = DW'(rev >> (7'(XLEN) - n));
                d.carry_en = 1'b0;
            end
`ifdef BITWISE_COUNT_EN
            OP_POPCNT: begin
                cnt = 7'd0;
                for (int i = 0; i < XLEN; i++) cnt = cnt + 7'(a[i]);
                d.src      = DW'(cnt);
                d.carry_en = 1'b0;
            end
            OP_CLZ: begin
                cnt = n;
                for (int i = 0; i < XLEN; i++)
                    if ((7'(i) < n) && a[i]) cnt = n - 7'(i) - 7'd1;
                d.src      = DW'(cnt);
                d.carry_en = 1'b0;
            end
`endif
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // First partial shift: low three bits of the shift amount.
    function automatic dec_t f_sh_lo(input dec_t d);
        dec_t o;
        o     = d;
        o.src = d.src >> d.sh[2:0];
        o.sh  = {d.sh[6:3], 3'b000};
        return o;
    endfunction

    // Remaining shift, extraction, size mask, carry and illegal gating.
    function automatic res_t f_fin(input dec_t d);
        res_t            o;
        logic [DW-1:0]   u;
        logic [XLEN-1:0] res;
        logic            c;
        u   = d.src >> d.sh;
        res = d.lo_mode ? u[XLEN-1:0] : u[XLEN:1];
        c   = d.lo_mode ? u[IW'(d.n)] : u[0];
        res = res & f_mask(d.n);
        if (d.fill_en) res = res | (XLEN'(d.fill) << (d.n - 7'd1));
        o.res     = d.illegal ? '0 : res;
        o.carry   = c & d.carry_en & ~d.illegal;
        o.illegal = d.illegal;
        return o;
    endfunction

    dec_t dec_in;
    dec_t d_last;
    logic v_last;
    res_t fin;
    logic adv;

    // Whole pipe moves together whenever the output slot is free or drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Decode of the live request.
    always_comb begin
        dec_in = f_dec(in_op, in_size, in_use_c, in_carry, in_a, in_b);
    end

    generate
        if (STAGES == 1) begin : g_s1
            assign d_last = f_sh_lo(dec_in);
            assign v_last = in_valid;
        end else if (STAGES == 2) begin : g_s2
            dec_t s1;
            logic v1;
            // Stage 1: decoded and masked request.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1 <= 1'b0;
                    s1 <= '0;
                end else if (adv) begin
                    v1 <= in_valid;
                    s1 <= dec_in;
                end
            end
            assign d_last = f_sh_lo(s1);
            assign v_last = v1;
        end else begin : g_s3
            dec_t s1, s2;
            logic v1, v2;
            // Stage 1 decode, stage 2 first partial shift.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1 <= 1'b0;
                    v2 <= 1'b0;
                    s1 <= '0;
                    s2 <= '0;
                end else if (adv) begin
                    v1 <= in_valid;
                    s1 <= dec_in;
                    v2 <= v1;
                    s2 <= f_sh_lo(s1);
                end
            end
            assign d_last = s2;
            assign v_last = v2;
        end
    endgenerate

    // Final-stage result computation.
    always_comb begin
        fin = f_fin(d_last);
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_carry   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (adv) begin
            out_valid   <= v_last;
            out_result  <= fin.res;
            out_carry   <= fin.carry;
            out_illegal <= fin.illegal;
        end
    end

endmodule
